// File: rtl/sparce_types_pkg.sv
// Types shared by the SparCE SASA blocks: loader FSM states and the entry word layout.
// The CHECK state exists only when SASA_LOADER_CHECKSUM_EN is defined.
package sparce_types_pkg;

  localparam int SASA_WORDS_PER_ENTRY = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
`ifdef SASA_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } loader_state_t;

  // Second word of an entry; the first word is the preceding_pc.
  typedef struct packed {
    logic [3:0]  reserved;
    logic [15:0] insts_to_skip;
    logic [1:0]  condition;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
  } sasa_entry_cfg_t;

endpackage

// File: rtl/sasa_table_loader.sv
// Sequencer that copies packed SASA entry words from memory into the SASA table.
// Define SASA_LOADER_CHECKSUM_EN to verify a trailing XOR checksum word after the data.
module sasa_table_loader
  import sparce_types_pkg::*;
#(
  parameter logic [31:0] SASA_ADDR_BASE  = 32'h0000_1000,
  parameter int          WORDS_PER_ENTRY = SASA_WORDS_PER_ENTRY,
  parameter int          MAX_ENTRIES     = 16,
  parameter int          ENTRY_CNT_W     = $clog2(MAX_ENTRIES + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            src_addr,
  input  logic [ENTRY_CNT_W-1:0] num_entries,
  input  logic                   enable_req,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   mem_ren,
  output logic [31:0]            mem_addr,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_busy,
  output logic                   sasa_wen,
  output logic [31:0]            sasa_addr,
  output logic [31:0]            sasa_data,
  output logic                   sasa_enable
);

  localparam int TOT_W = ENTRY_CNT_W + $clog2(WORDS_PER_ENTRY) + 1;

  loader_state_t    state, state_nxt;
  logic [TOT_W-1:0] word_idx, total;
  logic [31:0]      src_q, data_q, word_off;
  logic             error_q, table_valid, commit_q;
  logic             last_word, start_bad;

`ifdef SASA_LOADER_CHECKSUM_EN
  logic [31:0] xor_q, total_off;
  assign total_off = 32'({total, 2'b00});
`endif

  assign word_off  = 32'({word_idx, 2'b00});
  assign last_word = (word_idx == total - TOT_W'(1));
  assign start_bad = (32'(num_entries) > MAX_ENTRIES) || (src_addr[1:0] != 2'b00);

  assign error       = error_q;
  assign sasa_enable = enable_req & table_valid & (state == S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    mem_ren   = 1'b0;
    mem_addr  = '0;
    sasa_wen  = 1'b0;
    sasa_addr = '0;
    sasa_data = '0;
    case (state)
      S_IDLE: if (start) state_nxt = (start_bad || num_entries == '0) ? S_DONE : S_READ;
      S_READ: begin
        mem_ren  = 1'b1;
        mem_addr = src_q + word_off;
        if (abort)          state_nxt = S_DONE;
        else if (!mem_busy) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        sasa_wen  = 1'b1;
        sasa_addr = SASA_ADDR_BASE + word_off;
        sasa_data = data_q;
        if (abort) state_nxt = S_DONE;
`ifdef SASA_LOADER_CHECKSUM_EN
        else if (last_word) state_nxt = S_CHECK;
`else
        else if (last_word) state_nxt = S_DONE;
`endif
        else state_nxt = S_READ;
      end
`ifdef SASA_LOADER_CHECKSUM_EN
      S_CHECK: begin
        mem_ren  = 1'b1;
        mem_addr = src_q + total_off;
        if (abort || !mem_busy) state_nxt = S_DONE;
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // commit_q marks a load that ran to completion; only then may DONE publish the table.
  always_ff @(posedge CLK) begin
    if (RST) begin
      src_q       <= '0;
      total       <= '0;
      word_idx    <= '0;
      data_q      <= '0;
      error_q     <= 1'b0;
      table_valid <= 1'b0;
      commit_q    <= 1'b0;
`ifdef SASA_LOADER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          src_q       <= src_addr;
          total       <= TOT_W'(num_entries) * TOT_W'(WORDS_PER_ENTRY);
          word_idx    <= '0;
          error_q     <= start_bad;
          table_valid <= 1'b0;
          commit_q    <= 1'b0;
`ifdef SASA_LOADER_CHECKSUM_EN
          xor_q       <= '0;
`endif
        end
        S_READ: if (!abort && !mem_busy) begin
          data_q <= mem_rdata;
`ifdef SASA_LOADER_CHECKSUM_EN
          xor_q  <= xor_q ^ mem_rdata;
`endif
        end
        S_WRITE: if (!abort) begin
          if (!last_word) word_idx <= word_idx + TOT_W'(1);
`ifndef SASA_LOADER_CHECKSUM_EN
          else            commit_q <= 1'b1;
`endif
        end
`ifdef SASA_LOADER_CHECKSUM_EN
        S_CHECK: if (!abort && !mem_busy) begin
          if (mem_rdata == xor_q) commit_q <= 1'b1;
          else                    error_q  <= 1'b1;
        end
`endif
        S_DONE:  table_valid <= commit_q & ~error_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sasa_table_loader.sv
// Randomized self-checking bench for sasa_table_loader against a transaction-level model.
module tb_sasa_table_loader;
  localparam int ENTRY_CNT_W = 5;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic                   start = 1'b0, abort = 1'b0, enable_req = 1'b0;
  logic [31:0]            src_addr = '0;
  logic [ENTRY_CNT_W-1:0] num_entries = '0;
  logic                   busy, done, error, mem_ren, mem_busy, sasa_wen, sasa_enable;
  logic [31:0]            mem_addr, mem_rdata, sasa_addr, sasa_data;

  logic [31:0] mem [0:4095];
  int          waits [0:63];
  int          rd_idx = 0, busy_cnt = 0, edge_cnt = 0;
  logic        rd_clr = 1'b0;
  int          n_chk = 0, n_err = 0;

  sasa_table_loader dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .src_addr(src_addr),
    .num_entries(num_entries), .enable_req(enable_req), .busy(busy), .done(done),
    .error(error), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_busy(mem_busy), .sasa_wen(sasa_wen), .sasa_addr(sasa_addr),
    .sasa_data(sasa_data), .sasa_enable(sasa_enable)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Memory model: each read is held busy for waits[read number] cycles.
  assign mem_rdata = mem[mem_addr[13:2]];
  assign mem_busy  = mem_ren && (busy_cnt < ((rd_idx < 64) ? waits[rd_idx] : 0));
  always @(posedge CLK) begin
    if (rd_clr) begin
      rd_idx <= 0; busy_cnt <= 0;
    end else if (mem_ren) begin
      if (mem_busy) busy_cnt <= busy_cnt + 1;
      else begin busy_cnt <= 0; rd_idx <= rd_idx + 1; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_waits();
    for (int i = 0; i < 64; i++) waits[i] = 0;
  endtask

  // One load: drive start, watch the table port, then compare against the model.
  task automatic run_load(input int n, input logic [31:0] src, input logic en,
                          input int abort_at, input bit poke, input bit corrupt);
    logic [31:0] wa[$], wd[$];
    logic [31:0] csum, addr_prev;
    int          k, lat, total, base, exp_lat, exp_writes, unstable;
    bit          legal, got_done, aborted, exp_err, exp_valid, busy_prev;
    total = n * 2;
    base  = int'(src[13:2]);
    legal = (n <= 16) && (src[1:0] == 2'b00);
    csum  = '0;
    for (int i = 0; i < total; i++) csum ^= mem[(base + i) % 4096];
    mem[(base + total) % 4096] = corrupt ? ~csum : csum;

    exp_err   = !legal;
    exp_valid = legal && n > 0 && abort_at < 0;
    exp_lat   = 0;
    exp_writes = (legal && n > 0) ? total : 0;
    if (abort_at >= 0) exp_writes = abort_at;
    if (exp_valid) begin
      exp_lat = 2 * total;
      for (int i = 0; i < total; i++) exp_lat += waits[i];
`ifdef SASA_LOADER_CHECKSUM_EN
      exp_lat += 1 + waits[total];
      if (corrupt) begin exp_err = 1'b1; exp_valid = 1'b0; end
`endif
    end

    @(negedge CLK);
    start = 1'b1; src_addr = src; num_entries = ENTRY_CNT_W'(n);
    enable_req = en; rd_clr = 1'b1;
    k = edge_cnt + 1;
    got_done = 0; aborted = 0; unstable = 0; busy_prev = 0; addr_prev = '0; lat = -1;
    for (int i = 0; i < 2000 && !got_done; i++) begin
      @(negedge CLK);
      start = 1'b0; abort = 1'b0; rd_clr = 1'b0;
      if (poke && i == 3) begin start = 1'b1; src_addr = 32'h3001; num_entries = 5'd7; end
      if (sasa_wen) begin wa.push_back(sasa_addr); wd.push_back(sasa_data); end
      if (mem_busy && busy_prev && mem_addr != addr_prev) unstable++;
      if (sasa_wen && mem_ren) unstable++;
      busy_prev = mem_busy; addr_prev = mem_addr;
      if (done) begin got_done = 1; lat = edge_cnt - k; end
      else if (abort_at >= 0 && !aborted && wa.size() == abort_at) begin
        abort = 1'b1; aborted = 1;
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    if (abort_at < 0) chk("latency", 32'(lat), 32'(exp_lat));
    chk("write_cnt", 32'(wa.size()), 32'(exp_writes));
    for (int i = 0; i < wa.size() && i < exp_writes; i++) begin
      chk("wr_addr", wa[i], 32'h1000 + 32'(4 * i));
      chk("wr_data", wd[i], mem[(base + i) % 4096]);
    end
    chk("rd_stable", 32'(unstable), 32'd0);
    chk("error", 32'(error), 32'(exp_err));
    @(negedge CLK);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("idle", {31'd0, busy}, 32'd0);
    chk("enable", {31'd0, sasa_enable}, 32'(en & exp_valid));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    clear_waits();
    enable_req = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_flags", {26'd0, busy, done, error, mem_ren, sasa_wen, sasa_enable}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_saddr", sasa_addr | sasa_data, 32'd0);
    RST = 1'b0;

    run_load(3, 32'h2000, 1'b1, -1, 0, 0);          // basic zero-wait load
    waits[2] = 3;
    run_load(3, 32'h2000, 1'b1, -1, 0, 0);          // stall on word 2
    clear_waits();
    run_load(17, 32'h2000, 1'b1, -1, 0, 0);         // too many entries
    run_load(2, 32'h2002, 1'b1, -1, 0, 0);          // misaligned source
    run_load(0, 32'h2000, 1'b1, -1, 0, 0);          // empty table
    run_load(4, 32'h2100, 1'b1, 2, 0, 0);           // abort after 2 writes
    run_load(4, 32'h2100, 1'b1, -1, 1, 0);          // clean reload, start poked while busy
    run_load(16, 32'h2200, 1'b1, -1, 0, 0);         // max size

`ifdef SASA_LOADER_CHECKSUM_EN
    run_load(2, 32'h2400, 1'b1, -1, 0, 1);          // corrupted checksum
    waits[4] = 2;
    run_load(2, 32'h2400, 1'b1, -1, 0, 0);          // stalled checksum read
    clear_waits();
`endif

    for (int r = 0; r < 12; r++) begin
      int n, ab;
      n  = $urandom_range(1, 16);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * n - 1) : -1;
      for (int i = 0; i < 64; i++) waits[i] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2);
      run_load(n, 32'h2000 + 32'(4 * $urandom_range(0, 1000)), 1'($urandom_range(0, 1)), ab,
               1'($urandom_range(0, 1)), 0);
    end
    clear_waits();

    // Reset in the middle of a load: back to idle, no done, table disabled.
    @(negedge CLK);
    start = 1'b1; src_addr = 32'h2000; num_entries = 5'd4; enable_req = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_flags", {26'd0, busy, done, error, mem_ren, sasa_wen, sasa_enable}, 32'd0);
    chk("mid_rst_addr", mem_addr | sasa_addr | sasa_data, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_en", {31'd0, sasa_enable}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sasa_table_loader.md
Name: sasa_table_loader

Overview:
- DMA-style sequencer that programs the SparCE SASA table; it is the write side of the table's sasa_addr/sasa_data/sasa_wen port.
- On a start command it reads packed SASA entry words from a memory buffer over a generic read port and replays each word as a one-cycle table write.
- It gates sasa_enable so skipping is suppressed while the table is partially programmed.
- Sits beside the SparCE internal block; it is driven by CSR-side start/abort logic.

Parameters:
- SASA_ADDR_BASE, 32'h0000_1000, table config address of word 0; word i goes to SASA_ADDR_BASE + 4*i.
- WORDS_PER_ENTRY, 2, 32-bit words per SASA entry (preceding_pc word, packed rs1/rs2/condition/insts_to_skip word).
- MAX_ENTRIES, 16, largest legal num_entries.
- ENTRY_CNT_W, $clog2(MAX_ENTRIES+1), width of num_entries.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- start  in  1  load request pulse.
- abort  in  1  cancel an in-progress load.
- src_addr  in  32  word-aligned buffer base address.
- num_entries  in  ENTRY_CNT_W  entry count.
- enable_req  in  1  software-requested SASA enable.
- busy  out  1  high when the FSM is not in IDLE.
- done  out  1  one-cycle completion pulse (success, error or abort).
- error  out  1  sticky status of the last load.
- mem_ren  out  1  memory read request.
- mem_addr  out  32  read address.
- mem_rdata  in  32  read data.
- mem_busy  in  1  high while the read is pending.
- sasa_wen  out  1  table write strobe.
- sasa_addr  out  32  table write address.
- sasa_data  out  32  table write data.
- sasa_enable  out  1  table enable.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; word_idx = 0; table_valid = 0; data_q = 0.
- sasa_enable = enable_req & table_valid & (state == IDLE). Combinational from registers.
- start is honoured only in IDLE and is ignored while busy.
- On an accepted start:
  - latch src_addr and total = num_entries * WORDS_PER_ENTRY.
  - clear error, clear table_valid, set word_idx = 0.
- Parameter checks on an accepted start:
  - num_entries == 0: go to DONE and leave table_valid at 0 after DONE (empty table).
  - num_entries > MAX_ENTRIES, or src_addr[1:0] != 0: set error = 1, go to DONE, issue no writes.
- FSM states: IDLE, READ, WRITE, (CHECK), DONE.
- READ:
  - mem_ren = 1 and mem_addr = src + 4*word_idx, both held stable while mem_busy = 1.
  - In the first cycle with mem_busy = 0, capture mem_rdata into data_q and go to WRITE.
- WRITE (exactly one cycle):
  - sasa_wen = 1, sasa_addr = SASA_ADDR_BASE + 4*word_idx, sasa_data = data_q.
  - If word_idx == total-1, go to DONE (or CHECK when the feature is enabled); otherwise increment word_idx and return to READ.
- DONE (one cycle): done = 1; table_valid = ~error; then go to IDLE.
- Latency with zero memory wait: start sampled at edge k, READ begins in cycle k+1, done is high in cycle k+1+2*total. Each memory wait cycle adds one cycle.
- abort:
  - In READ or WRITE, go to DONE next cycle; a WRITE already in progress completes that cycle.
  - table_valid stays 0 and error stays 0 (a partial table remains disabled).
  - abort in IDLE or DONE has no effect. If start and abort are asserted together in IDLE, start wins.
- Arithmetic: address computations are modulo 2^32; the multiply for total is sized to ENTRY_CNT_W + $clog2(WORDS_PER_ENTRY) + 1 bits.
- RST mid-load: returns to IDLE on the next edge; table_valid = 0; no done pulse.

Optional Feature:
- Macro: SASA_LOADER_CHECKSUM_EN.
- With the macro defined:
  - the FSM adds state CHECK, which reads one extra word at src + 4*total with the same READ handshake.
  - that word is compared with the XOR of all data words; a mismatch sets error = 1, so table_valid stays 0.
  - zero-wait latency grows by 1 cycle.
- Without the macro: no CHECK state, no extra read, and no XOR register.

Decomposition:
- Shared package sparce_types_pkg holds:
  - the loader_state_t enum;
  - SASA_WORDS_PER_ENTRY;
  - a packed struct sasa_entry_cfg_t for word 1: rs1[4:0], rs2[4:0], condition[1:0], insts_to_skip[15:0], reserved.
- No sub-module; a single FSM plus counter. The address generation is inline.

Test Plan:
- num_entries = 3, src = 0x2000, zero-wait memory holding 6 known words -> 6 writes to 0x1000..0x1014 with matching data; done in cycle k+13; sasa_enable = 1 when enable_req = 1.
- mem_busy held for 3 cycles on word 2 -> mem_addr stable at 0x2008; no sasa_wen during the wait; done delayed by 3 cycles.
- num_entries = 17 -> error = 1, done pulse 1 cycle later, zero writes, sasa_enable = 0.
- abort after the 2nd write -> done pulses, exactly 2 writes, error = 0, sasa_enable = 0 despite enable_req = 1; a following clean load restores sasa_enable.
- start while busy, and RST asserted mid-load -> start ignored; after RST, all outputs 0 and the FSM is in IDLE.
- With SASA_LOADER_CHECKSUM_EN, corrupt the checksum word -> error = 1 and sasa_enable = 0. With a correct checksum -> error = 0 and done arrives 1 cycle later than without the feature.
